sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
Shares the single command/read port of the SDRAM controller (clk100 domain) between two requesters:
- Port A: acquisition writer, which stores meter samples.
- Port B: readback reader, which streams memory out over the UART.

It allows one command in flight at a time and at most one outstanding read. It routes returned read data back to whichever port issued the read, and flags reads that never complete.

Parameters:
PRIORITY_MODE, 0, 0 = round-robin between A and B; 1 = port A always wins a simultaneous request.
READ_TIMEOUT, 1023, cycles to wait in WAIT_RD for data_out_ready before abandoning the read (10-bit counter, minimum 1).

Ports:
clk  in  1  system clock (clk100)
rst  in  1  asynchronous, active-high reset
a_valid  in  1  port A request pending; held, with fields stable, until a_ack
a_wr  in  1  1 = write, 0 = read
a_addr  in  23  word address
a_data  in  32  write data
a_be  in  4  byte enables
a_ack  out  1  combinational; command accepted this cycle
a_rdata  out  32  read data, registered
a_rvalid  out  1  one-cycle pulse; a_rdata valid
b_valid, b_wr, b_addr, b_data, b_be, b_ack, b_rdata, b_rvalid: same as port A, for port B
cmd_ready  in  1  controller can accept a command
cmd_enable  out  1  to controller
cmd_wr  out  1  to controller
cmd_address  out  23  to controller
cmd_data_in  out  32  to controller
cmd_byte_enable  out  4  to controller
data_out  in  32  controller read data
data_out_ready  in  1  controller read-data strobe
busy  out  1  state != IDLE
rd_timeout  out  1  sticky; set on any read timeout, cleared only by rst

Behaviour:
- Reset values: state = IDLE; cmd_enable = 0; cmd_wr = 0; cmd_address = 0; cmd_data_in = 0; cmd_byte_enable = 0; a_rdata = 0; b_rdata = 0; a_rvalid = 0; b_rvalid = 0; rd_timeout = 0; last_grant = B (so A wins the first tie); timer = 0; all acks low.
- Command acceptance: a command is accepted on any rising edge where cmd_enable = 1 and cmd_ready = 1.
- State IDLE:
  - If a_valid or b_valid, select a grant: if only one port is valid it wins; if both are valid, PRIORITY_MODE = 1 gives A, and PRIORITY_MODE = 0 gives the port that is not last_grant.
  - Register the winner's wr, addr, data and be into the cmd_* outputs; set cmd_enable = 1 and last_grant = winner; go to ISSUE.
  - Latency: valid sampled at edge n, cmd_enable high from edge n on.
- State ISSUE:
  - Hold cmd_* stable.
  - x_ack = (state == ISSUE) and (grant == x) and cmd_ready. The requester drops valid or presents the next request at the same edge.
  - On acceptance: cmd_enable goes to 0. A write returns to IDLE; a read clears timer and goes to WAIT_RD.
  - There is no back-to-back issue: at least one IDLE cycle separates commands.
- State WAIT_RD:
  - On data_out_ready: register data_out into the granted port's rdata, pulse its rvalid for one cycle (the cycle after the strobe), go to IDLE.
  - Otherwise increment timer. When timer == READ_TIMEOUT - 1 and no strobe: set rd_timeout, go to IDLE, no rvalid.
  - If the strobe arrives on the same cycle the timeout would fire, the strobe wins.
- data_out_ready in IDLE or ISSUE (stray strobe, or late data after a timeout): ignored; no rvalid, no rdata change.
- Requests that arrive in ISSUE or WAIT_RD wait; nothing is dropped. A requester whose valid falls before ack is simply not served (a protocol violation, but harmless).
- Reset mid-operation: everything returns to its reset value immediately. An in-flight controller command is abandoned, and its later data strobe is ignored in IDLE.
- Address is passed through with no wrap or arithmetic; the full 23-bit range is legal, including 0x7FFFFF.

Decomposition:
- Shared package sdram_arb_pkg: state encodings (IDLE = 0, ISSUE = 1, WAIT_RD = 2), port IDs (PORT_A = 0, PORT_B = 1), address/data/byte-enable width constants (23/32/4).
- One sub-module, arb2_grant: purely combinational two-way grant from (a_valid, b_valid, last_grant, PRIORITY_MODE).
- Everything else stays in sdram_port_arbiter.

Test Plan:
- Single write: A writes addr 0x000010, data 0xDEADBEEF, be 0xF; cmd_ready held 1 -> cmd_enable high exactly 1 cycle with those fields; a_ack 1 cycle; returns to IDLE; no rvalid.
- Read return: B reads 0x7FFFFF; controller strobes data_out = 0x12345678 after 7 cycles -> b_rdata = 0x12345678, b_rvalid 1 cycle; a_rvalid stays 0.
- Simultaneous requests: both valid continuously, PRIORITY_MODE = 0 -> grant order A, B, A, B over 4 commands. With PRIORITY_MODE = 1 -> A, A, A while a_valid is held.
- Backpressure: cmd_ready low for 20 cycles during ISSUE -> cmd_* stable, no ack; ack fires on the first cycle cmd_ready = 1.
- Timeout: READ_TIMEOUT = 8, no strobe -> rd_timeout set after 8 WAIT_RD cycles, back to IDLE; a later stray strobe produces no rvalid.
- Reset in WAIT_RD: assert rst for 1 cycle -> all outputs at reset values the same cycle; the following strobe is ignored and the next request is served normally.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_arb_pkg
//  Description : Shared types and widths for the two-port SDRAM command
//                arbiter (state encoding, port identifiers, field widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

    localparam int c_ADDR_W  = 23;
    localparam int c_DATA_W  = 32;
    localparam int c_BE_W    = 4;
    localparam int c_TIMER_W = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

    // The port that did not win last time; used for round-robin fairness.
    function automatic port_id_t other_port(input port_id_t p);
        return (p == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb2_grant.sv
`default_nettype none
// ============================================================================
//  Module      : arb2_grant
//  Description : Combinational two-way grant. A lone requester always wins;
//                on a tie the winner is port A (fixed priority) or the port
//                that was not granted last (round-robin).
//  Revision    : 1.0 - initial release
// ============================================================================
module arb2_grant
    import sdram_arb_pkg::*;
#(
    parameter int PRIORITY_MODE = 0
) (
    input  logic     i_a_valid,
    input  logic     i_b_valid,
    input  port_id_t i_last_grant,
    output port_id_t o_grant,
    output logic     o_any_valid
);

    // Pick the winner from the current request pair and the grant history
    always_comb begin
        o_any_valid = i_a_valid | i_b_valid;
        o_grant     = PORT_A;
        if (i_a_valid && i_b_valid) begin
            o_grant = (PRIORITY_MODE == 1) ? PORT_A : other_port(i_last_grant);
        end else if (i_b_valid) begin
            o_grant = PORT_B;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_port_arbiter
//  Description : Shares the SDRAM controller command/read port between the
//                acquisition writer (A) and the readback reader (B). One
//                command in flight, at most one outstanding read, read data
//                steered back to the issuing port, sticky read-timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int PRIORITY_MODE = 0,
    parameter int READ_TIMEOUT  = 1023
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                a_valid,
    input  logic                a_wr,
    input  logic [c_ADDR_W-1:0] a_addr,
    input  logic [c_DATA_W-1:0] a_data,
    input  logic [c_BE_W-1:0]   a_be,
    output logic                a_ack,
    output logic [c_DATA_W-1:0] a_rdata,
    output logic                a_rvalid,

    input  logic                b_valid,
    input  logic                b_wr,
    input  logic [c_ADDR_W-1:0] b_addr,
    input  logic [c_DATA_W-1:0] b_data,
    input  logic [c_BE_W-1:0]   b_be,
    output logic                b_ack,
    output logic [c_DATA_W-1:0] b_rdata,
    output logic                b_rvalid,

    input  logic                cmd_ready,
    output logic                cmd_enable,
    output logic                cmd_wr,
    output logic [c_ADDR_W-1:0] cmd_address,
    output logic [c_DATA_W-1:0] cmd_data_in,
    output logic [c_BE_W-1:0]   cmd_byte_enable,

    input  logic [c_DATA_W-1:0] data_out,
    input  logic                data_out_ready,

    output logic                busy,
    output logic                rd_timeout
);

    // Last timer value before the read is abandoned; the timer starts at 0
    // on the first WAIT_RD cycle, so the read waits READ_TIMEOUT cycles.
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(READ_TIMEOUT - 1);

    arb_state_t             r_state;
    port_id_t               r_grant;
    port_id_t               r_last_grant;
    logic [c_TIMER_W-1:0]   r_timer;

    port_id_t               w_grant;
    logic                   w_any_valid;
    logic                   w_sel_wr;
    logic [c_ADDR_W-1:0]    w_sel_addr;
    logic [c_DATA_W-1:0]    w_sel_data;
    logic [c_BE_W-1:0]      w_sel_be;

    arb2_grant #(
        .PRIORITY_MODE (PRIORITY_MODE)
    ) u_grant (
        .i_a_valid    (a_valid),
        .i_b_valid    (b_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_any_valid  (w_any_valid)
    );

    // Route the winning requester's command fields toward the command register
    always_comb begin
        w_sel_wr   = a_wr;
        w_sel_addr = a_addr;
        w_sel_data = a_data;
        w_sel_be   = a_be;
        if (w_grant == PORT_B) begin
            w_sel_wr   = b_wr;
            w_sel_addr = b_addr;
            w_sel_data = b_data;
            w_sel_be   = b_be;
        end
    end

    // Acks tell the granted requester its command was taken at this edge
    assign a_ack = (r_state == ISSUE) && (r_grant == PORT_A) && cmd_ready;
    assign b_ack = (r_state == ISSUE) && (r_grant == PORT_B) && cmd_ready;
    assign busy  = (r_state != IDLE);

    // Arbitration FSM: grant in IDLE, hold the command in ISSUE until taken,
    // then wait for read data (or give up) in WAIT_RD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_grant         <= PORT_A;
            r_last_grant    <= PORT_B;
            r_timer         <= '0;
            cmd_enable      <= 1'b0;
            cmd_wr          <= 1'b0;
            cmd_address     <= '0;
            cmd_data_in     <= '0;
            cmd_byte_enable <= '0;
            a_rdata         <= '0;
            b_rdata         <= '0;
            a_rvalid        <= 1'b0;
            b_rvalid        <= 1'b0;
            rd_timeout      <= 1'b0;
        end else begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        cmd_enable      <= 1'b1;
                        cmd_wr          <= w_sel_wr;
                        cmd_address     <= w_sel_addr;
                        cmd_data_in     <= w_sel_data;
                        cmd_byte_enable <= w_sel_be;
                        r_grant         <= w_grant;
                        r_last_grant    <= w_grant;
                        r_state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        cmd_enable <= 1'b0;
                        if (cmd_wr) begin
                            r_state <= IDLE;
                        end else begin
                            r_timer <= '0;
                            r_state <= WAIT_RD;
                        end
                    end
                end
                WAIT_RD: begin
                    // A strobe on the final timer cycle still counts as data
                    if (data_out_ready) begin
                        if (r_grant == PORT_A) begin
                            a_rdata  <= data_out;
                            a_rvalid <= 1'b1;
                        end else begin
                            b_rdata  <= data_out;
                            b_rvalid <= 1'b1;
                        end
                        r_state <= IDLE;
                    end else if (r_timer == c_TIMER_LAST) begin
                        rd_timeout <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_port_arbiter
//  Description : Scoreboard bench for sdram_port_arbiter. Requester queues
//                feed both ports, a controller model answers reads, and a
//                negedge monitor compares the DUT against expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

    localparam int     RT   = 8;
    localparam longint LMAX = 64'sh7FFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic        wr;
        logic [22:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } req_t;

    typedef struct {
        int          port;
        logic [31:0] data;
        longint      cyc;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld   [2];
    logic        wr    [2];
    logic [22:0] addr  [2];
    logic [31:0] data  [2];
    logic [3:0]  be    [2];
    logic        ack   [2];
    logic [31:0] rdata [2];
    logic        rvalid[2];
    logic        cmd_ready, cmd_enable, cmd_wr;
    logic [22:0] cmd_address;
    logic [31:0] cmd_data_in;
    logic [3:0]  cmd_byte_enable;
    logic [31:0] data_out;
    logic        data_out_ready, busy, rd_timeout;

    // second instance, fixed priority, driven only in its own short phase
    logic        p1_a_valid, p1_b_valid, p1_a_ack, p1_b_ack, p1_a_rvalid, p1_b_rvalid;
    logic [31:0] p1_a_rdata, p1_b_rdata, p1_cmd_data_in;
    logic        p1_cmd_ready, p1_cmd_enable, p1_cmd_wr, p1_busy, p1_rd_timeout;
    logic [22:0] p1_cmd_address;
    logic [3:0]  p1_cmd_byte_enable;

    req_t        rq[2][$];
    rd_t         exp_rd[$];
    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;

    // reference model state
    bit          m_granted = 0;
    int          m_port = 0;
    int          m_last = 1;
    req_t        m_cmd;
    longint      m_free_at = 0;
    longint      to_cycle = LMAX;
    logic [31:0] m_rdata[2] = '{32'h0, 32'h0};

    // controller / stimulus knobs
    longint      strobe_due = -1;
    longint      pending_until = 0;
    logic [31:0] strobe_data = 32'h0;
    int          force_k = -1;
    logic [31:0] force_data = 32'h0;
    int          ready_mode = 0;
    int          ready_low = 0;
    bit          stray_en = 0;
    longint      rd_acc_cyc = -1;

    sdram_port_arbiter #(.PRIORITY_MODE(0), .READ_TIMEOUT(RT)) dut (
        .clk(clk), .rst(rst),
        .a_valid(vld[0]), .a_wr(wr[0]), .a_addr(addr[0]), .a_data(data[0]), .a_be(be[0]),
        .a_ack(ack[0]), .a_rdata(rdata[0]), .a_rvalid(rvalid[0]),
        .b_valid(vld[1]), .b_wr(wr[1]), .b_addr(addr[1]), .b_data(data[1]), .b_be(be[1]),
        .b_ack(ack[1]), .b_rdata(rdata[1]), .b_rvalid(rvalid[1]),
        .cmd_ready(cmd_ready), .cmd_enable(cmd_enable), .cmd_wr(cmd_wr),
        .cmd_address(cmd_address), .cmd_data_in(cmd_data_in), .cmd_byte_enable(cmd_byte_enable),
        .data_out(data_out), .data_out_ready(data_out_ready),
        .busy(busy), .rd_timeout(rd_timeout)
    );

    sdram_port_arbiter #(.PRIORITY_MODE(1), .READ_TIMEOUT(RT)) dut_p1 (
        .clk(clk), .rst(rst),
        .a_valid(p1_a_valid), .a_wr(1'b1), .a_addr(23'h000001), .a_data(32'hAAAA_0001), .a_be(4'hF),
        .a_ack(p1_a_ack), .a_rdata(p1_a_rdata), .a_rvalid(p1_a_rvalid),
        .b_valid(p1_b_valid), .b_wr(1'b1), .b_addr(23'h000002), .b_data(32'hBBBB_0002), .b_be(4'hF),
        .b_ack(p1_b_ack), .b_rdata(p1_b_rdata), .b_rvalid(p1_b_rvalid),
        .cmd_ready(p1_cmd_ready), .cmd_enable(p1_cmd_enable), .cmd_wr(p1_cmd_wr),
        .cmd_address(p1_cmd_address), .cmd_data_in(p1_cmd_data_in), .cmd_byte_enable(p1_cmd_byte_enable),
        .data_out(32'h0), .data_out_ready(1'b0),
        .busy(p1_busy), .rd_timeout(p1_rd_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic present(input int p);
        vld[p] = 1'b1;
        {wr[p], addr[p], data[p], be[p]} = rq[p][0];
    endtask

    // Requester: presents queued commands in order, holding each until acked
    task automatic requester(input int p);
        forever begin
            @(posedge clk);
            #1;
            if (rq[p].size() > 0 && !rst) begin
                present(p);
                while (1) begin
                    int w;
                    bit got;
                    w = 0;
                    got = 0;
                    while (!got && w < 300) begin
                        @(negedge clk);
                        if (ack[p]) got = 1;
                        w++;
                    end
                    if (!got) begin
                        checks++;
                        errors++;
                        $display("FAIL ack_wait port %0d: got no ack expected ack within 300 cycles", p);
                        vld[p] = 1'b0;
                        rq[p].delete();
                        break;
                    end
                    @(posedge clk);
                    #1;
                    void'(rq[p].pop_front());
                    if (rq[p].size() > 0) begin
                        present(p);
                    end else begin
                        vld[p] = 1'b0;
                        break;
                    end
                end
            end
        end
    endtask

    initial requester(0);
    initial requester(1);

    // Controller side: ready policy and read-data strobes
    initial forever begin
        @(posedge clk);
        #1;
        if (ready_low > 0) begin
            cmd_ready = 1'b0;
            ready_low--;
        end else begin
            cmd_ready = (ready_mode == 0) ? 1'b1 : ($urandom % 4 != 0);
        end
        if (cyc + 1 == strobe_due) begin
            data_out_ready = 1'b1;
            data_out       = strobe_data;
        end else if (stray_en && cyc >= pending_until && ($urandom % 10 == 0)) begin
            data_out_ready = 1'b1;
            data_out       = $urandom;
        end else begin
            data_out_ready = 1'b0;
            data_out       = $urandom;
        end
    end

    // Reference model + monitor, evaluated mid-cycle
    task automatic model_step();
        bit          acc;
        bit          ea, eb;
        int          win, k;
        longint      p_edge;
        logic [31:0] d;
        rd_t         e;
        if (rst) begin
            chk("reset_ctrl", {cmd_enable, cmd_wr, cmd_address, cmd_byte_enable, busy,
                               rd_timeout, ack[0], ack[1], rvalid[0], rvalid[1]}, 64'h0);
            chk("reset_cmd_data", cmd_data_in, 64'h0);
            chk("reset_rdata", {rdata[0], rdata[1]}, 64'h0);
            m_granted = 0;
            m_last    = 1;
            m_free_at = 0;
            to_cycle  = LMAX;
            m_rdata   = '{32'h0, 32'h0};
            exp_rd.delete();
            return;
        end
        acc = m_granted && cmd_ready;
        chk("busy", busy, (m_granted || cyc < m_free_at));
        chk("cmd_enable", cmd_enable, m_granted);
        chk("a_ack", ack[0], acc && m_port == 0);
        chk("b_ack", ack[1], acc && m_port == 1);
        if (m_granted)
            chk("cmd_fields", {cmd_wr, cmd_address, cmd_data_in, cmd_byte_enable}, m_cmd);
        chk("rd_timeout", rd_timeout, cyc >= to_cycle);

        ea = 0;
        eb = 0;
        if (exp_rd.size() > 0 && exp_rd[0].cyc == cyc) begin
            e = exp_rd.pop_front();
            if (e.port == 0) ea = 1; else eb = 1;
            m_rdata[e.port] = e.data;
        end
        chk("rvalid_ab", {rvalid[0], rvalid[1]}, {ea, eb});
        chk("a_rdata", rdata[0], m_rdata[0]);
        chk("b_rdata", rdata[1], m_rdata[1]);

        if (acc) begin
            m_granted = 0;
            if (m_cmd.wr) begin
                m_free_at = cyc + 1;
            end else begin
                p_edge = cyc + 1;
                if (force_k >= 0) begin
                    k = force_k;
                    d = force_data;
                end else begin
                    k = $urandom % 12;
                    k = (k < 8) ? k + 1 : ((k == 8) ? RT + 1 : 0);
                    d = $urandom;
                end
                strobe_data = d;
                rd_acc_cyc  = p_edge;
                if (k >= 1 && k <= RT) begin
                    e.port = m_port;
                    e.data = d;
                    e.cyc  = p_edge + k;
                    exp_rd.push_back(e);
                    m_free_at     = p_edge + k;
                    strobe_due    = p_edge + k;
                    pending_until = p_edge + k;
                end else begin
                    m_free_at = p_edge + RT;
                    if (to_cycle > p_edge + RT) to_cycle = p_edge + RT;
                    strobe_due    = (k > 0) ? p_edge + k : -1;
                    pending_until = (k > 0) ? p_edge + k : p_edge + RT;
                end
            end
        end

        if (!m_granted && cyc >= m_free_at && (vld[0] || vld[1])) begin
            if (vld[0] && vld[1]) win = (m_last == 0) ? 1 : 0;
            else                  win = vld[0] ? 0 : 1;
            m_port    = win;
            m_last    = win;
            m_granted = 1;
            m_cmd     = {wr[win], addr[win], data[win], be[win]};
        end
    endtask

    always @(negedge clk) model_step();

    task automatic push(input int p, input logic w, input logic [22:0] a,
                        input logic [31:0] dd, input logic [3:0] b);
        req_t r;
        r = {w, a, dd, b};
        rq[p].push_back(r);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rq[0].size() > 0 || rq[1].size() > 0 || vld[0] || vld[1] ||
                m_granted || cyc < m_free_at) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got still busy expected idle within 5000 cycles");
        end
        repeat (12) @(posedge clk);
    endtask

    initial begin
        int n;
        int pa;
        req_t r;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            vld[i] = 0; wr[i] = 0; addr[i] = '0; data[i] = '0; be[i] = '0;
        end
        cmd_ready = 0; data_out = 0; data_out_ready = 0;
        p1_a_valid = 0; p1_b_valid = 0; p1_cmd_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // single write from A
        push(0, 1'b1, 23'h000010, 32'hDEADBEEF, 4'hF);
        wait_idle();

        // B reads the top address, data returns 7 cycles later
        force_k = 7;
        force_data = 32'h12345678;
        push(1, 1'b0, 23'h7FFFFF, 32'h0, 4'hF);
        wait_idle();
        force_k = -1;

        // both ports busy: round-robin alternation
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b1, 23'(i), 32'hA000_0000 + i, 4'h3);
            push(1, 1'b1, 23'h100 + 23'(i), 32'hB000_0000 + i, 4'hC);
        end
        wait_idle();

        // backpressure: cmd_ready low for a long stretch while in ISSUE
        ready_low = 22;
        push(0, 1'b1, 23'h2AAAAA, 32'h5555AAAA, 4'h5);
        wait_idle();

        // timeout with no strobe, then stray strobes while idle
        force_k = 0;
        push(0, 1'b0, 23'h000123, 32'h0, 4'hF);
        wait_idle();
        force_k = -1;
        stray_en = 1;
        repeat (30) @(posedge clk);
        stray_en = 0;

        // reset while waiting for read data; the late strobe must be ignored
        force_k = 6;
        force_data = 32'hCAFEF00D;
        rd_acc_cyc = -1;
        push(1, 1'b0, 23'h000055, 32'h0, 4'hF);
        n = 0;
        while (rd_acc_cyc < 0 && n < 200) begin @(posedge clk); n++; end
        chk("reset_test_read_accepted", (rd_acc_cyc >= 0), 64'h1);
        while (cyc < rd_acc_cyc + 2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        force_k = -1;
        while (cyc <= strobe_due + 2) @(posedge clk);
        push(0, 1'b1, 23'h000077, 32'h01020304, 4'h9);
        wait_idle();

        // randomized traffic on both ports
        ready_mode = 1;
        stray_en = 1;
        for (int i = 0; i < 160; i++) begin
            pa = $urandom % 2;
            r.wr   = $urandom % 2;
            case ($urandom % 8)
                0:       r.addr = 23'h7FFFFF;
                1:       r.addr = 23'h000000;
                default: r.addr = 23'($urandom);
            endcase
            r.data = $urandom;
            r.be   = 4'($urandom);
            if (rq[pa].size() < 3) rq[pa].push_back(r);
            repeat ($urandom % 4) @(posedge clk);
        end
        wait_idle();
        stray_en = 0;
        ready_mode = 0;
        chk("reads_outstanding", exp_rd.size(), 64'h0);

        // fixed priority: A wins every tie while held
        @(posedge clk);
        #1;
        p1_a_valid = 1;
        p1_b_valid = 1;
        p1_cmd_ready = 1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (p1_a_ack || p1_b_ack) begin
                n++;
                chk("prio_a_ack", p1_a_ack, 64'h1);
                chk("prio_b_ack", p1_b_ack, 64'h0);
            end
        end
        chk("prio_accepts", n, 64'd6);
        @(posedge clk);
        #1;
        p1_a_valid = 0;
        p1_b_valid = 0;
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
